// File: rtl/mem_arbiter_if.sv
// Client-side request/response bundle for the CHIP-8 memory arbiter.
// One instance per client (CPU, sprite/GPU engine). The client drives the
// request fields through the master modport; the arbiter returns the grant
// and the read response through the slave modport.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client arbiter for the 4 KiB CHIP-8 memory.
// The read and write ports are arbitrated independently, so one read and one
// write from different clients can issue in the same cycle. Memory-side
// controls are registered. Each issued read carries an owner tag through a
// two-stage pipeline that lines up with the memory's one-cycle acknowledge,
// so the response is steered back to the client that asked for it.
module mem_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      cpu,
    mem_arbiter_if.slave      gpu,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_idx,
    input  logic [DATA_W-1:0] mem_read_byte,
    input  logic              mem_read_ack,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_write_idx,
    output logic [DATA_W-1:0] mem_write_byte
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_GPU = 1'b1
    } owner_t;

    // Grant vector encoding: bit 0 = CPU wins, bit 1 = GPU wins.
    // With both clients contending, round-robin hands the port to whichever
    // client did not win it last; fixed priority always favours the CPU.
    function automatic logic [1:0] arbitrate(
        input logic   cpu_cand,
        input logic   gpu_cand,
        input owner_t last
    );
        logic [1:0] win;
        case ({cpu_cand, gpu_cand})
            2'b00:   win = 2'b00;
            2'b10:   win = 2'b01;
            2'b01:   win = 2'b10;
            2'b11: begin
                if ((ROUND_ROBIN == 1'b1) && (last == OWN_CPU)) begin
                    win = 2'b10;
                end else begin
                    win = 2'b01;
                end
            end
            default: win = 2'b00;
        endcase
        return win;
    endfunction

    // Arbitration state and pipeline registers
    owner_t            last_rd_r;
    owner_t            last_wr_r;
    logic              tag1_valid_r;
    owner_t            tag1_owner_r;
    logic              tag2_valid_r;
    owner_t            tag2_owner_r;

    // Combinational arbitration results
    logic              cpu_rd_s;
    logic              gpu_rd_s;
    logic              cpu_wr_s;
    logic              gpu_wr_s;
    logic [1:0]        rd_win_s;
    logic [1:0]        wr_win_s;
    logic              rd_any_s;
    logic              wr_any_s;
    owner_t            rd_owner_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              cpu_hit_s;
    logic              gpu_hit_s;

    // Classify requests per port and pick the winner of each port; nothing is granted in reset
    always_comb begin
        cpu_rd_s = cpu.req & ~cpu.we;
        gpu_rd_s = gpu.req & ~gpu.we;
        cpu_wr_s = cpu.req &  cpu.we;
        gpu_wr_s = gpu.req &  gpu.we;
        rd_win_s = 2'b00;
        wr_win_s = 2'b00;
        if (!rst_n) begin
            rd_win_s = 2'b00;
            wr_win_s = 2'b00;
        end else begin
            rd_win_s = arbitrate(cpu_rd_s, gpu_rd_s, last_rd_r);
            wr_win_s = arbitrate(cpu_wr_s, gpu_wr_s, last_wr_r);
        end
    end

    // Derive grants and the address/data of each port's winner
    always_comb begin
        cpu.gnt    = rd_win_s[0] | wr_win_s[0];
        gpu.gnt    = rd_win_s[1] | wr_win_s[1];
        rd_any_s   = |rd_win_s;
        wr_any_s   = |wr_win_s;
        rd_owner_s = OWN_CPU;
        rd_addr_s  = cpu.addr;
        wr_addr_s  = cpu.addr;
        wr_data_s  = cpu.wdata;
        if (rd_win_s[1]) begin
            rd_owner_s = OWN_GPU;
            rd_addr_s  = gpu.addr;
        end else begin
            rd_owner_s = OWN_CPU;
            rd_addr_s  = cpu.addr;
        end
        if (wr_win_s[1]) begin
            wr_addr_s = gpu.addr;
            wr_data_s = gpu.wdata;
        end else begin
            wr_addr_s = cpu.addr;
            wr_data_s = cpu.wdata;
        end
    end

    // Steer the memory's read response to the client named by the oldest tag
    always_comb begin
        cpu_hit_s  = mem_read_ack & tag2_valid_r & (tag2_owner_r == OWN_CPU);
        gpu_hit_s  = mem_read_ack & tag2_valid_r & (tag2_owner_r == OWN_GPU);
        cpu.rvalid = cpu_hit_s;
        gpu.rvalid = gpu_hit_s;
        if (cpu_hit_s) begin
            cpu.rdata = mem_read_byte;
        end else begin
            cpu.rdata = {DATA_W{1'b0}};
        end
        if (gpu_hit_s) begin
            gpu.rdata = mem_read_byte;
        end else begin
            gpu.rdata = {DATA_W{1'b0}};
        end
    end

    // Read port issue: strobe every granted cycle, address held while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read     <= 1'b0;
            mem_read_idx <= {ADDR_W{1'b0}};
        end else begin
            mem_read <= rd_any_s;
            if (rd_any_s) begin
                mem_read_idx <= rd_addr_s;
            end
        end
    end

    // Owner tag pipeline: stage 1 tracks the issued strobe, stage 2 aligns with the ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_valid_r <= 1'b0;
            tag1_owner_r <= OWN_CPU;
            tag2_valid_r <= 1'b0;
            tag2_owner_r <= OWN_CPU;
        end else begin
            tag1_valid_r <= rd_any_s;
            tag1_owner_r <= rd_owner_s;
            tag2_valid_r <= tag1_valid_r;
            tag2_owner_r <= tag1_owner_r;
        end
    end

    // Write port issue: strobe every granted cycle, address and data held while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write      <= 1'b0;
            mem_write_idx  <= {ADDR_W{1'b0}};
            mem_write_byte <= {DATA_W{1'b0}};
        end else begin
            mem_write <= wr_any_s;
            if (wr_any_s) begin
                mem_write_idx  <= wr_addr_s;
                mem_write_byte <= wr_data_s;
            end
        end
    end

    // Round-robin pointers: remember the last winner of each port on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_r <= OWN_GPU;
            last_wr_r <= OWN_GPU;
        end else begin
            if (rd_any_s) begin
                last_rd_r <= rd_owner_s;
            end
            if (wr_win_s[1]) begin
                last_wr_r <= OWN_GPU;
            end else if (wr_win_s[0]) begin
                last_wr_r <= OWN_CPU;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance wired to a small
// memory model, plus a fixed-priority instance fed the same requests whose
// grants are checked against the CPU-always-wins rule.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_ack = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) cpu_if ();
    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) gpu_if ();
    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) cpu_fp ();
    mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) gpu_fp ();

    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte = 8'h00;
    logic        mem_read_ack = 1'b0;
    logic        mem_write;
    logic [11:0] mem_write_idx;
    logic [7:0]  mem_write_byte;

    logic        fp_read;
    logic [11:0] fp_read_idx;
    logic        fp_write;
    logic [11:0] fp_write_idx;
    logic [7:0]  fp_write_byte;

    mem_arbiter #(.ADDR_W(12), .DATA_W(8), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cpu(cpu_if), .gpu(gpu_if),
        .mem_read(mem_read), .mem_read_idx(mem_read_idx),
        .mem_read_byte(mem_read_byte), .mem_read_ack(mem_read_ack),
        .mem_write(mem_write), .mem_write_idx(mem_write_idx),
        .mem_write_byte(mem_write_byte)
    );

    mem_arbiter #(.ADDR_W(12), .DATA_W(8), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .cpu(cpu_fp), .gpu(gpu_fp),
        .mem_read(fp_read), .mem_read_idx(fp_read_idx),
        .mem_read_byte(8'h00), .mem_read_ack(1'b0),
        .mem_write(fp_write), .mem_write_idx(fp_write_idx),
        .mem_write_byte(fp_write_byte)
    );

    assign cpu_fp.req   = cpu_if.req;
    assign cpu_fp.we    = cpu_if.we;
    assign cpu_fp.addr  = cpu_if.addr;
    assign cpu_fp.wdata = cpu_if.wdata;
    assign gpu_fp.req   = gpu_if.req;
    assign gpu_fp.we    = gpu_if.we;
    assign gpu_fp.addr  = gpu_if.addr;
    assign gpu_fp.wdata = gpu_if.wdata;

    // Memory model: loaded on the first edge, reads before writes, one-cycle ack
    logic [7:0] mem [0:4095];
    logic       loaded = 1'b0;

    function automatic logic [7:0] preset(input int a);
        case (a)
            12'h300: return 8'h33;
            12'h050: return 8'h5A;
            12'h200: return 8'hA2;
            12'h123: return 8'h11;
            12'h000: return 8'h10;
            12'h001: return 8'h21;
            12'h002: return 8'h32;
            12'h003: return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    // Memory model behaviour
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= preset(i);
            loaded <= 1'b1;
            mem_read_ack <= 1'b0;
        end else begin
            if (mem_write) mem[mem_write_idx] <= mem_write_byte;
            if (mem_read) mem_read_byte <= mem[mem_read_idx];
            mem_read_ack <= mem_read | force_ack;
        end
    end

    typedef struct {
        logic        c_req, c_we;
        logic [11:0] c_addr;
        logic [7:0]  c_wd;
        logic        g_req, g_we;
        logic [11:0] g_addr;
        logic [7:0]  g_wd;
        logic        e_cgnt, e_ggnt;
        logic        e_crv;
        logic [7:0]  e_crd;
        logic        e_grv;
        logic [7:0]  e_grd;
        logic        e_mrd;
        logic [11:0] e_mrd_idx;
        logic        e_mwr;
        logic [11:0] e_mwr_idx;
        logic [7:0]  e_mwr_byte;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int vi, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, vi, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [11:0] ca, input logic [7:0] cd,
                         input logic gr, input logic gw, input logic [11:0] ga, input logic [7:0] gd);
        cpu_if.req = cr; cpu_if.we = cw; cpu_if.addr = ca; cpu_if.wdata = cd;
        gpu_if.req = gr; gpu_if.we = gw; gpu_if.addr = ga; gpu_if.wdata = gd;
    endtask

    task automatic chk_all_zero(input int tag);
        chk("rst_mem_read", tag, 32'(mem_read), 32'h0);
        chk("rst_mem_read_idx", tag, 32'(mem_read_idx), 32'h0);
        chk("rst_mem_write", tag, 32'(mem_write), 32'h0);
        chk("rst_mem_write_idx", tag, 32'(mem_write_idx), 32'h0);
        chk("rst_mem_write_byte", tag, 32'(mem_write_byte), 32'h0);
        chk("rst_cpu_gnt", tag, 32'(cpu_if.gnt), 32'h0);
        chk("rst_gpu_gnt", tag, 32'(gpu_if.gnt), 32'h0);
        chk("rst_cpu_rvalid", tag, 32'(cpu_if.rvalid), 32'h0);
        chk("rst_gpu_rvalid", tag, 32'(gpu_if.rvalid), 32'h0);
        chk("rst_fp_cpu_gnt", tag, 32'(cpu_fp.gnt), 32'h0);
    endtask

    initial begin
        // inputs                                              cgnt ggnt  crv crd   grv grd   mrd idx      mwr idx     byte
        vecs[0]  = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[1]  = '{1'b1,1'b0,12'h300,8'h00, 1'b1,1'b0,12'h050,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[2]  = '{1'b1,1'b0,12'h300,8'h00, 1'b1,1'b0,12'h050,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1,12'h300, 1'b0,12'h000,8'h00};
        vecs[3]  = '{1'b1,1'b0,12'h300,8'h00, 1'b1,1'b0,12'h050,8'h00, 1'b1,1'b0, 1'b1,8'h33, 1'b0,8'h00, 1'b1,12'h050, 1'b0,12'h000,8'h00};
        vecs[4]  = '{1'b1,1'b0,12'h300,8'h00, 1'b1,1'b0,12'h050,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b1,8'h5A, 1'b1,12'h300, 1'b0,12'h000,8'h00};
        vecs[5]  = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b1,8'h33, 1'b0,8'h00, 1'b1,12'h050, 1'b0,12'h000,8'h00};
        vecs[6]  = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b1,8'h5A, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[7]  = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[8]  = '{1'b1,1'b0,12'h200,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[9]  = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1,12'h200, 1'b0,12'h000,8'h00};
        vecs[10] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b1,8'hA2, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[11] = '{1'b1,1'b1,12'h123,8'h55, 1'b1,1'b0,12'h123,8'h00, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[12] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,12'h123,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1,12'h123, 1'b1,12'h123,8'h55};
        vecs[13] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b1,8'h11, 1'b1,12'h123, 1'b0,12'h000,8'h00};
        vecs[14] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b1,8'h55, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[15] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,1'b1,12'h7FF,8'h99, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[16] = '{1'b1,1'b1,12'h010,8'h01, 1'b1,1'b1,12'h011,8'h02, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b1,12'h7FF,8'h99};
        vecs[17] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,1'b1,12'h011,8'h02, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b1,12'h010,8'h01};
        vecs[18] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b1,12'h011,8'h02};
        vecs[19] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[20] = '{1'b1,1'b0,12'h010,8'h00, 1'b1,1'b0,12'h011,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[21] = '{1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0,12'h011,8'h00, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 1'b1,12'h010, 1'b0,12'h000,8'h00};
        vecs[22] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b1,8'h01, 1'b0,8'h00, 1'b1,12'h011, 1'b0,12'h000,8'h00};
        vecs[23] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b1,8'h02, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[24] = '{1'b1,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[25] = '{1'b1,1'b0,12'h001,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b1,12'h000, 1'b0,12'h000,8'h00};
        vecs[26] = '{1'b1,1'b0,12'h002,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0, 1'b1,8'h10, 1'b0,8'h00, 1'b1,12'h001, 1'b0,12'h000,8'h00};
        vecs[27] = '{1'b1,1'b0,12'h003,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b1,1'b0, 1'b1,8'h21, 1'b0,8'h00, 1'b1,12'h002, 1'b0,12'h000,8'h00};
        vecs[28] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b1,8'h32, 1'b0,8'h00, 1'b1,12'h003, 1'b0,12'h000,8'h00};
        vecs[29] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b1,8'h43, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};
        vecs[30] = '{1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0,12'h000,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 1'b0,12'h000, 1'b0,12'h000,8'h00};

        // Reset with a CPU read request held: nothing may be granted or strobed
        drive(1'b1, 1'b0, 12'h200, 8'h00, 1'b1, 1'b1, 12'h040, 8'h77);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero(-1);

        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wd,
                  vecs[i].g_req, vecs[i].g_we, vecs[i].g_addr, vecs[i].g_wd);
            @(negedge clk);
            chk("cpu_gnt", i, 32'(cpu_if.gnt), 32'(vecs[i].e_cgnt));
            chk("gpu_gnt", i, 32'(gpu_if.gnt), 32'(vecs[i].e_ggnt));
            chk("cpu_rvalid", i, 32'(cpu_if.rvalid), 32'(vecs[i].e_crv));
            chk("gpu_rvalid", i, 32'(gpu_if.rvalid), 32'(vecs[i].e_grv));
            chk("mem_read", i, 32'(mem_read), 32'(vecs[i].e_mrd));
            chk("mem_write", i, 32'(mem_write), 32'(vecs[i].e_mwr));
            if (vecs[i].e_crv) chk("cpu_rdata", i, 32'(cpu_if.rdata), 32'(vecs[i].e_crd));
            if (vecs[i].e_grv) chk("gpu_rdata", i, 32'(gpu_if.rdata), 32'(vecs[i].e_grd));
            if (vecs[i].e_mrd) chk("mem_read_idx", i, 32'(mem_read_idx), 32'(vecs[i].e_mrd_idx));
            if (vecs[i].e_mwr) begin
                chk("mem_write_idx", i, 32'(mem_write_idx), 32'(vecs[i].e_mwr_idx));
                chk("mem_write_byte", i, 32'(mem_write_byte), 32'(vecs[i].e_mwr_byte));
            end
            // Fixed priority: CPU always wins its port, GPU only when the CPU is not on the same port
            chk("fp_cpu_gnt", i, 32'(cpu_fp.gnt), 32'(vecs[i].c_req));
            chk("fp_gpu_gnt", i, 32'(gpu_fp.gnt),
                32'(vecs[i].g_req & ~(vecs[i].c_req & (vecs[i].c_we == vecs[i].g_we))));
            @(posedge clk); #1;
        end

        // CPU read granted, then reset in the next cycle while acks keep arriving
        drive(1'b1, 1'b0, 12'h200, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
        @(negedge clk);
        chk("mid_cpu_gnt", 100, 32'(cpu_if.gnt), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        chk_all_zero(101);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_ack_mem_read_ack", 102 + k, 32'(mem_read_ack), 32'h1);
            chk("late_ack_cpu_rvalid", 102 + k, 32'(cpu_if.rvalid), 32'h0);
            chk("late_ack_gpu_rvalid", 102 + k, 32'(gpu_if.rvalid), 32'h0);
            @(posedge clk); #1;
        end
        force_ack = 1'b0;

        // Read pointer was left at CPU before reset; reset must return it to GPU
        drive(1'b1, 1'b0, 12'h300, 8'h00, 1'b1, 1'b0, 12'h050, 8'h00);
        @(negedge clk);
        chk("ptr_rst_cpu_gnt", 110, 32'(cpu_if.gnt), 32'h1);
        chk("ptr_rst_gpu_gnt", 110, 32'(gpu_if.gnt), 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
